// File: rtl/anc_adapt_scheduler.sv
// anc_adapt_scheduler: per-sample sequencer for the adaptive noise-cancellation
// datapath. Each accepted reference sample is written into the circular buffer.
// The FIR is then launched, the error sample is awaited, and one LMS update is
// issued once warm-up is complete and adaptation is enabled.
// Optional build macro: ANC_DIAG_CNT_EN adds saturating overrun/timeout counters.
module anc_adapt_scheduler #(
    parameter int ARRAY_SIZE     = 256,
    parameter int OFFSET_W       = 8,
    parameter int WARMUP_SAMPLES = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                sample_valid_in,
    input  logic [15:0]         sample_in,
    input  logic                adapt_en_in,
    input  logic                fir_done_in,
    input  logic                error_valid_in,
    input  logic                lms_done_in,
    output logic                wr_en_out,
    output logic [OFFSET_W-1:0] wr_addr_out,
    output logic [15:0]         wr_data_out,
    output logic [OFFSET_W-1:0] offset_out,
    output logic                fir_start_out,
    output logic                lms_ready_out,
    output logic                busy_out,
    output logic                warm_out,
    output logic                overrun_out,
    output logic                timeout_out
`ifdef ANC_DIAG_CNT_EN
    ,
    output logic [15:0]         overrun_cnt_out,
    output logic [15:0]         timeout_cnt_out
`endif
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_FIR_RUN  = 3'd2;
    localparam logic [2:0] ST_ERR_WAIT = 3'd3;
    localparam logic [2:0] ST_LMS_RUN  = 3'd4;

    localparam int WU_W = $clog2(WARMUP_SAMPLES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WU_W-1:0]     WU_MAX     = WU_W'(WARMUP_SAMPLES);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [OFFSET_W-1:0] OFFSET_RST = OFFSET_W'(ARRAY_SIZE - 1);

    // Next ring index; the buffer size is a power of two so the wrap is natural.
    function automatic logic [OFFSET_W-1:0] ring_next(input logic [OFFSET_W-1:0] idx);
        return idx + OFFSET_W'(1);
    endfunction

    logic [2:0]          state_r;
    logic [2:0]          state_nxt_s;
    logic [WD_W-1:0]     wd_r;
    logic [WU_W-1:0]     wu_r;
    logic [WU_W-1:0]     wu_nxt_s;
    logic                wait_s;
    logic                timeout_s;
    logic                start_s;
    logic                overrun_s;
    logic                wr_en_r;
    logic [OFFSET_W-1:0] wr_addr_r;
    logic [15:0]         wr_data_r;
    logic [OFFSET_W-1:0] offset_r;
    logic                fir_start_r;
    logic                lms_ready_r;
    logic                busy_r;
    logic                warm_r;
    logic                overrun_r;
    logic                timeout_r;

    // Next-state, watchdog expiry, sample acceptance and warm-up count decode.
    always_comb begin
        state_nxt_s = state_r;
        wait_s      = 1'b0;
        timeout_s   = 1'b0;
        start_s     = 1'b0;
        overrun_s   = 1'b0;
        wu_nxt_s    = wu_r;
        case (state_r)
            ST_IDLE: begin
                if (sample_valid_in) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_nxt_s = ST_FIR_RUN;
            end
            ST_FIR_RUN: begin
                wait_s = 1'b1;
                if (fir_done_in) begin
                    state_nxt_s = ST_ERR_WAIT;
                end else begin
                    state_nxt_s = ST_FIR_RUN;
                end
            end
            ST_ERR_WAIT: begin
                wait_s = 1'b1;
                if (error_valid_in) begin
                    if (adapt_en_in && warm_r) begin
                        state_nxt_s = ST_LMS_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_ERR_WAIT;
                end
            end
            ST_LMS_RUN: begin
                wait_s = 1'b1;
                // A done coinciding with the ready pulse belongs to no request yet.
                if (lms_done_in && !lms_ready_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LMS_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // Watchdog only fires if the state would otherwise stay put.
        if (wait_s && (state_nxt_s == state_r) && (wd_r == WD_LAST)) begin
            timeout_s   = 1'b1;
            state_nxt_s = ST_IDLE;
        end else begin
            timeout_s   = 1'b0;
        end
        if (state_r != ST_IDLE) begin
            overrun_s = sample_valid_in;
        end else begin
            overrun_s = 1'b0;
        end
        if (start_s && (wu_r != WU_MAX)) begin
            wu_nxt_s = wu_r + WU_W'(1);
        end else begin
            wu_nxt_s = wu_r;
        end
    end

    // Control state, watchdog, warm-up tracking and pulse outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r     <= ST_IDLE;
            wd_r        <= {WD_W{1'b0}};
            wu_r        <= {WU_W{1'b0}};
            warm_r      <= 1'b0;
            busy_r      <= 1'b0;
            fir_start_r <= 1'b0;
            lms_ready_r <= 1'b0;
            overrun_r   <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            if ((state_nxt_s != state_r) || !wait_s) begin
                wd_r <= {WD_W{1'b0}};
            end else begin
                wd_r <= wd_r + WD_W'(1);
            end
            wu_r        <= wu_nxt_s;
            warm_r      <= (wu_nxt_s == WU_MAX);
            busy_r      <= (state_nxt_s != ST_IDLE);
            fir_start_r <= (state_nxt_s == ST_FIR_RUN) && (state_r != ST_FIR_RUN);
            lms_ready_r <= (state_nxt_s == ST_LMS_RUN) && (state_r != ST_LMS_RUN);
            overrun_r   <= overrun_s;
            timeout_r   <= timeout_s;
        end
    end

    // Buffer write port and ring offset; the offset moves with the write strobe.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {OFFSET_W{1'b0}};
            wr_data_r <= 16'h0000;
            offset_r  <= OFFSET_RST;
        end else if (start_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= ring_next(offset_r);
            wr_data_r <= sample_in;
            offset_r  <= ring_next(offset_r);
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
            offset_r  <= offset_r;
        end
    end

`ifdef ANC_DIAG_CNT_EN
    logic [15:0] overrun_cnt_r;
    logic [15:0] timeout_cnt_r;

    // Saturating diagnostic counters, stepped together with their pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overrun_cnt_r <= 16'h0000;
            timeout_cnt_r <= 16'h0000;
        end else begin
            if (overrun_s && (overrun_cnt_r != 16'hFFFF)) begin
                overrun_cnt_r <= overrun_cnt_r + 16'h0001;
            end else begin
                overrun_cnt_r <= overrun_cnt_r;
            end
            if (timeout_s && (timeout_cnt_r != 16'hFFFF)) begin
                timeout_cnt_r <= timeout_cnt_r + 16'h0001;
            end else begin
                timeout_cnt_r <= timeout_cnt_r;
            end
        end
    end

    assign overrun_cnt_out = overrun_cnt_r;
    assign timeout_cnt_out = timeout_cnt_r;
`endif

    assign wr_en_out     = wr_en_r;
    assign wr_addr_out   = wr_addr_r;
    assign wr_data_out   = wr_data_r;
    assign offset_out    = offset_r;
    assign fir_start_out = fir_start_r;
    assign lms_ready_out = lms_ready_r;
    assign busy_out      = busy_r;
    assign warm_out      = warm_r;
    assign overrun_out   = overrun_r;
    assign timeout_out   = timeout_r;

endmodule

// File: tb/tb_anc_adapt_scheduler.sv
// Bench for anc_adapt_scheduler: randomized sample periods checked against a
// transaction-level model (ring offset, accepted-sample count, pulse tallies).
module tb_anc_adapt_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] sample;
    logic        adapt_en;
    logic        fir_done;
    logic        error_valid;
    logic        lms_done;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  offset;
    logic        fir_start;
    logic        lms_ready;
    logic        busy;
    logic        warm;
    logic        overrun;
    logic        timeout;
`ifdef ANC_DIAG_CNT_EN
    logic [15:0] overrun_cnt;
    logic [15:0] timeout_cnt;
`endif

    int total = 0;
    int bad   = 0;
    // Reference model: newest ring index, accepted samples, pulse tallies.
    int m_off = 255;
    int m_cnt = 0;
    int m_ovr = 0;
    int m_tmo = 0;

    always #5 clk = ~clk;

    anc_adapt_scheduler dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .sample_valid_in (sample_valid),
        .sample_in       (sample),
        .adapt_en_in     (adapt_en),
        .fir_done_in     (fir_done),
        .error_valid_in  (error_valid),
        .lms_done_in     (lms_done),
        .wr_en_out       (wr_en),
        .wr_addr_out     (wr_addr),
        .wr_data_out     (wr_data),
        .offset_out      (offset),
        .fir_start_out   (fir_start),
        .lms_ready_out   (lms_ready),
        .busy_out        (busy),
        .warm_out        (warm),
        .overrun_out     (overrun),
        .timeout_out     (timeout)
`ifdef ANC_DIAG_CNT_EN
        ,
        .overrun_cnt_out (overrun_cnt),
        .timeout_cnt_out (timeout_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete sample period with random wait lengths and stray pulses.
    task automatic do_period(input logic [15:0] smp, input logic adapt, input bit ovr_fir, input bit ovr_lms);
        int fd;
        int ed;
        int ld;
        logic [7:0] exp_addr;
        bit exp_lms;
        fd = int'($urandom_range(4, 1));
        ed = int'($urandom_range(3, 0));
        ld = int'($urandom_range(3, 0));
        exp_addr = 8'((m_off + 1) % 256);
        sample_valid = 1'b1; sample = smp;
        tick;
        sample_valid = 1'b0; sample = 16'($urandom);
        m_off = int'(exp_addr);
        m_cnt++;
        total++; if (wr_en !== 1'b1 || wr_addr !== exp_addr || wr_data !== smp) begin bad++; $display("FAIL write: en=%b addr=%0d data=%h want en=1 addr=%0d data=%h", wr_en, wr_addr, wr_data, exp_addr, smp); end
        total++; if (offset !== exp_addr) begin bad++; $display("FAIL offset_adv: got %0d want %0d", offset, exp_addr); end
        total++; if (warm !== (m_cnt >= 256)) begin bad++; $display("FAIL warm: got %b want %b (samples=%0d)", warm, (m_cnt >= 256), m_cnt); end
        tick;
        total++; if (fir_start !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL fir_start: start=%b wr_en=%b want 1/0", fir_start, wr_en); end
        for (int i = 0; i < fd; i++) begin
            sample_valid = (ovr_fir && i == 0);
            error_valid  = 1'($urandom_range(1, 0));
            lms_done     = 1'($urandom_range(1, 0));
            tick;
            if (ovr_fir && i == 0) begin
                m_ovr++;
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_fir: got %b want 1", overrun); end
            end
            total++; if (fir_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL fir_wait: start=%b busy=%b want 0/1", fir_start, busy); end
        end
        sample_valid = 1'b0; error_valid = 1'b0; lms_done = 1'b0;
        fir_done = 1'b1;
        tick;
        fir_done = 1'b0;
        total++; if (offset !== exp_addr) begin bad++; $display("FAIL offset_hold: got %0d want %0d", offset, exp_addr); end
        for (int i = 0; i < ed; i++) begin
            fir_done = 1'($urandom_range(1, 0));
            lms_done = 1'($urandom_range(1, 0));
            tick;
            total++; if (busy !== 1'b1 || lms_ready !== 1'b0) begin bad++; $display("FAIL err_wait: busy=%b ready=%b want 1/0", busy, lms_ready); end
        end
        fir_done = 1'b0; lms_done = 1'b0;
        exp_lms = adapt && (m_cnt >= 256);
        error_valid = 1'b1; adapt_en = adapt;
        tick;
        error_valid = 1'b0; adapt_en = 1'($urandom_range(1, 0));
        total++; if (lms_ready !== exp_lms || busy !== exp_lms) begin bad++; $display("FAIL lms_decision: ready=%b busy=%b want %b", lms_ready, busy, exp_lms); end
        if (exp_lms) begin
            lms_done = 1'b1;
            tick;
            lms_done = 1'b0;
            total++; if (busy !== 1'b1 || lms_ready !== 1'b0) begin bad++; $display("FAIL early_done: busy=%b ready=%b want 1/0", busy, lms_ready); end
            for (int i = 0; i < ld; i++) tick;
            lms_done = 1'b1; sample_valid = ovr_lms;
            tick;
            lms_done = 1'b0; sample_valid = 1'b0;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL lms_finish: busy=%b want 0", busy); end
            if (ovr_lms) begin
                m_ovr++;
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_done: got %b want 1", overrun); end
            end
        end
        tick;
        total++; if (busy !== 1'b0 || overrun !== 1'b0 || timeout !== 1'b0 || offset !== exp_addr) begin bad++; $display("FAIL idle_end: busy=%b ovr=%b tmo=%b off=%0d want 0/0/0/%0d", busy, overrun, timeout, offset, exp_addr); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sample_valid = 1'b0; sample = 16'h0000; adapt_en = 1'b0;
        fir_done = 1'b0; error_valid = 1'b0; lms_done = 1'b0;
        tick; tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        total++; if (offset !== 8'd255 || wr_addr !== 8'd0 || wr_data !== 16'h0000) begin bad++; $display("FAIL reset_data: off=%0d addr=%0d data=%h want 255/0/0", offset, wr_addr, wr_data); end
        total++; if ({wr_en, fir_start, lms_ready, busy, warm, overrun, timeout} !== 7'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000000", {wr_en, fir_start, lms_ready, busy, warm, overrun, timeout}); end
`ifdef ANC_DIAG_CNT_EN
        total++; if (overrun_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: %0d/%0d want 0/0", overrun_cnt, timeout_cnt); end
`endif
    endtask

    task automatic test_first_sample;
        do_period(16'h1234, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_warmup;
        for (int n = 0; n < 255; n++) do_period(16'($urandom), 1'($urandom_range(1, 0)), 1'b0, 1'b0);
        do_period(16'($urandom), 1'b1, 1'b0, 1'b0);
        total++; if (offset !== 8'd0) begin bad++; $display("FAIL wrap: offset=%0d want 0", offset); end
    endtask

    task automatic test_adapt_toggle;
        do_period(16'($urandom), 1'b0, 1'b0, 1'b0);
        do_period(16'($urandom), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overrun;
        do_period(16'($urandom), 1'b1, 1'b1, 1'b1);
`ifdef ANC_DIAG_CNT_EN
        total++; if (overrun_cnt !== 16'(m_ovr)) begin bad++; $display("FAIL ovr_cnt: got %0d want %0d", overrun_cnt, m_ovr); end
`endif
    endtask

    task automatic test_timeout;
        int n;
        sample_valid = 1'b1; sample = 16'($urandom);
        tick;
        sample_valid = 1'b0;
        m_off = (m_off + 1) % 256; m_cnt++;
        tick;
        n = 0;
        while (n < 1100) begin
            tick;
            n++;
            if (timeout === 1'b1) break;
        end
        m_tmo++;
        total++; if (n !== 1024) begin bad++; $display("FAIL timeout_time: cycles=%0d want 1024", n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: busy=%b want 0", busy); end
`ifdef ANC_DIAG_CNT_EN
        total++; if (timeout_cnt !== 16'(m_tmo)) begin bad++; $display("FAIL tmo_cnt: got %0d want %0d", timeout_cnt, m_tmo); end
`endif
        tick;
        total++; if (timeout !== 1'b0 || offset !== 8'(m_off)) begin bad++; $display("FAIL timeout_after: tmo=%b off=%0d want 0/%0d", timeout, offset, m_off); end
        do_period(16'($urandom), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_lms;
        sample_valid = 1'b1; sample = 16'($urandom);
        tick;
        sample_valid = 1'b0;
        tick;
        fir_done = 1'b1; tick; fir_done = 1'b0;
        error_valid = 1'b1; adapt_en = 1'b1; tick; error_valid = 1'b0;
        total++; if (lms_ready !== 1'b1) begin bad++; $display("FAIL pre_reset_lms: ready=%b want 1", lms_ready); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (offset !== 8'd255 || busy !== 1'b0 || lms_ready !== 1'b0 || warm !== 1'b0) begin bad++; $display("FAIL async_reset: off=%0d busy=%b ready=%b warm=%b want 255/0/0/0", offset, busy, lms_ready, warm); end
`ifdef ANC_DIAG_CNT_EN
        total++; if (overrun_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin bad++; $display("FAIL async_reset_cnt: %0d/%0d want 0/0", overrun_cnt, timeout_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        m_off = 255; m_cnt = 0; m_ovr = 0; m_tmo = 0;
        tick;
        do_period(16'($urandom), 1'b1, 1'b1, 1'b0);
        total++; if (offset !== 8'd0) begin bad++; $display("FAIL post_reset_offset: got %0d want 0", offset); end
`ifdef ANC_DIAG_CNT_EN
        total++; if (overrun_cnt !== 16'(m_ovr) || timeout_cnt !== 16'(m_tmo)) begin bad++; $display("FAIL post_reset_cnt: %0d/%0d want %0d/%0d", overrun_cnt, timeout_cnt, m_ovr, m_tmo); end
`endif
    endtask

    initial begin
        test_reset;
        test_first_sample;
        test_warmup;
        test_adapt_toggle;
        test_overrun;
        test_timeout;
        test_reset_mid_lms;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/anc_adapt_scheduler.md
Name: anc_adapt_scheduler

Overview:
- Per-sample sequencer for the adaptive noise-cancellation datapath.
- On each new reference sample it:
  - writes the sample into the 256-entry circular sample buffer,
  - advances the ring offset,
  - launches the FIR output computation,
  - waits for the error sample,
  - fires one coefficient-update strobe (ready/done handshake) into the LMS/NLMS update block.
- Sits between the audio front end and the filter/update datapath.
- Owns the ring offset, warm-up gating, the overrun policy and the watchdog.

Parameters:
- ARRAY_SIZE, 256, sample buffer / coefficient count; must be a power of two.
- OFFSET_W, 8, width of ring index, log2(ARRAY_SIZE).
- WARMUP_SAMPLES, 256, accepted samples required before adaptation is permitted.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in any wait state.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- sample_valid_in  input  1  one-cycle strobe, new reference sample
- sample_in  input  16  signed reference sample
- adapt_en_in  input  1  level; 0 freezes coefficient updates
- fir_done_in  input  1  FIR output computed (pulse)
- error_valid_in  input  1  error sample for this period available (pulse)
- lms_done_in  input  1  update block finished (pulse)
- wr_en_out  output  1  sample buffer write strobe
- wr_addr_out  output  OFFSET_W  sample buffer write address
- wr_data_out  output  16  sample buffer write data
- offset_out  output  OFFSET_W  index of newest sample, fed to the FIR and update blocks
- fir_start_out  output  1  one-cycle FIR launch pulse
- lms_ready_out  output  1  one-cycle update strobe to the update block's ready input
- busy_out  output  1  high whenever the state is not IDLE
- warm_out  output  1  warm-up complete
- overrun_out  output  1  one-cycle pulse, sample dropped
- timeout_out  output  1  one-cycle pulse, watchdog expired

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - offset_out=ARRAY_SIZE-1, so the first write lands at address 0.
  - All strobes, busy_out and warm_out = 0.
  - wr_addr_out, wr_data_out, warm-up counter and watchdog = 0.
- Reset mid-operation aborts immediately. No pulse is emitted; the state returns to IDLE.
- States: IDLE, WRITE, FIR_RUN, ERR_WAIT, LMS_RUN.
- IDLE:
  - When sample_valid_in=1, register sample_in and go to WRITE.
- WRITE (one cycle):
  - Assert wr_en_out with wr_addr_out=offset_out+1 (mod ARRAY_SIZE, natural wrap 255->0) and wr_data_out=the latched sample.
  - offset_out takes the new address on the same edge that wr_en_out is asserted.
  - Increment the warm-up counter, saturating at WARMUP_SAMPLES.
  - Go to FIR_RUN.
- FIR_RUN:
  - fir_start_out pulses in the first cycle of FIR_RUN, i.e. one cycle after the write, so the buffer is updated first.
  - Wait for fir_done_in, then go to ERR_WAIT.
- ERR_WAIT:
  - On error_valid_in: if adapt_en_in=1 and warm_out=1, go to LMS_RUN; otherwise go to IDLE.
  - adapt_en_in is sampled in the same cycle as error_valid_in.
- LMS_RUN:
  - lms_ready_out pulses in the first cycle.
  - Wait for lms_done_in, then go to IDLE.
  - lms_done_in arriving in the same cycle as the lms_ready_out pulse is ignored. Only done pulses after that cycle count.
- Done/valid pulses received in a state that is not waiting for them are ignored.
- warm_out = (warm-up counter == WARMUP_SAMPLES). It stays high until reset.
- Watchdog:
  - Clears on every state entry and counts cycles while in FIR_RUN, ERR_WAIT or LMS_RUN.
  - At TIMEOUT_CYCLES it pulses timeout_out and forces the state to IDLE.
  - offset_out and the warm-up counter are retained.
- Overrun:
  - sample_valid_in while the state is not IDLE pulses overrun_out the next cycle and drops the sample.
  - offset_out is unchanged.
  - This includes sample_valid_in in the same cycle as the final done/valid pulse that returns the block to IDLE.
- busy_out = (state != IDLE), registered.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro ANC_DIAG_CNT_EN.
- Defined:
  - Adds outputs overrun_cnt_out[15:0] and timeout_cnt_out[15:0].
  - Both counters saturate at 16'hFFFF and reset to 0.
  - Each increments on the same cycle its pulse is asserted.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then one sample 16'sh1234 with adapt_en_in=1:
  - wr_en_out at addr 0, data 16'h1234; offset_out=0.
  - fir_start_out pulses 1 cycle later.
  - After fir_done_in and error_valid_in there is no lms_ready_out (warm_out=0), and the block returns to IDLE.
- Feed 256 full periods:
  - warm_out rises on the WRITE of sample 256.
  - Sample 257 yields an lms_ready_out pulse after error_valid_in, and offset_out wraps 255->0.
- warm, adapt_en_in=0 at error_valid_in -> no lms_ready_out; IDLE next cycle. Toggle adapt_en_in to 1 next period -> lms_ready_out issued.
- sample_valid_in during FIR_RUN and again in the same cycle as lms_done_in:
  - overrun_out pulses twice.
  - offset_out advances only once, for the first sample.
- Withhold fir_done_in for 1024 cycles:
  - timeout_out pulses and the block is in IDLE.
  - The next sample is written at offset+1, with no lost offset.
- Assert rst_n_in low during LMS_RUN:
  - Outputs clear asynchronously and offset_out=255.
  - With ANC_DIAG_CNT_EN defined, the counters read 0 after reset and increment on the overrun and timeout pulses above.
